// File: rtl/alu_execute.sv
// alu_execute: two-stage pipelined ALU (add/sub/and/or/slt) with valid/ready handshakes and status flags
module alu_execute #(
  parameter int WIDTH = 16,
  parameter int TAGW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_code,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [TAGW-1:0]  dest_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAGW-1:0]  dest_out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             illegal,
  output logic [15:0]      retired
);
  logic             s1_valid;
  logic [3:0]       s1_code;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [TAGW-1:0]  s1_dest;
  logic             s2_free, s1_adv, accept;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] r;
  logic             c, v, ill;
  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !s1_valid || s2_free;
  assign accept   = in_valid && in_ready;
  assign sum      = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff     = {1'b0, s1_a} - {1'b0, s1_b};
  // diff's top bit is the unsigned borrow; overflow is judged from sign bits alone
  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    ill = 1'b0;
    case (s1_code)
      4'd0: r = '0;
      4'd1: begin
        r = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
      end
      4'd2: begin
        r = diff[WIDTH-1:0];
        c = diff[WIDTH];
        v = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
      end
      4'd3: r = s1_a & s1_b;
      4'd4: r = s1_a | s1_b;
      4'd5: r = {{(WIDTH-1){1'b0}}, $signed(s1_a) < $signed(s1_b)};
      default: ill = 1'b1;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_dest  <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_code  <= alu_code;
        s1_a     <= operand_a;
        s1_b     <= operand_b;
        s1_dest  <= dest_in;
      end else if (s1_adv) s1_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      dest_out  <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      illegal   <= 1'b0;
      retired   <= '0;
    end else begin
      if (s1_adv) begin
        out_valid <= 1'b1;
        result    <= r;
        dest_out  <= s1_dest;
        flag_z    <= r == '0;
        flag_n    <= r[WIDTH-1];
        flag_c    <= c;
        flag_v    <= v;
        illegal   <= ill;
      end else if (out_ready) out_valid <= 1'b0;
      if (out_valid && out_ready) retired <= retired + 16'd1;
    end
  end
endmodule

// File: tb/tb_alu_execute.sv
// tb_alu_execute: randomized scoreboard bench for alu_execute against an arithmetic reference model
module tb_alu_execute;
  typedef struct packed {
    logic [15:0] r;
    logic [3:0]  d;
    logic        z, n, c, v, ill;
  } exp_t;
  logic        clk = 1'b0, reset, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  alu_code, dest_in, dest_out;
  logic [15:0] operand_a, operand_b, result, retired;
  logic        flag_z, flag_n, flag_c, flag_v, illegal;
  int          tests = 0, fails = 0, hold = 0;
  bit          rnd = 0, saw_stall = 0;
  logic [15:0] exp_ret = 0;
  exp_t        q[$];
  alu_execute #(.WIDTH(16), .TAGW(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_code(alu_code), .operand_a(operand_a), .operand_b(operand_b), .dest_in(dest_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .dest_out(dest_out),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .illegal(illegal), .retired(retired)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(logic [3:0] code, logic [15:0] a, logic [15:0] b, logic [3:0] t);
    exp_t e;
    int sa, sb, s, u;
    sa = a[15] ? int'(a) - 65536 : int'(a);
    sb = b[15] ? int'(b) - 65536 : int'(b);
    e = '0;
    e.d = t;
    case (code)
      4'd0: e.r = 16'd0;
      4'd1: begin
        u = int'(a) + int'(b);
        s = sa + sb;
        e.r = u[15:0];
        e.c = u > 65535;
        e.v = s > 32767 || s < -32768;
      end
      4'd2: begin
        u = int'(a) - int'(b);
        s = sa - sb;
        e.r = u[15:0];
        e.c = a < b;
        e.v = s > 32767 || s < -32768;
      end
      4'd3: e.r = a & b;
      4'd4: e.r = a | b;
      4'd5: e.r = (sa < sb) ? 16'd1 : 16'd0;
      default: e.ill = 1'b1;
    endcase
    e.z = e.r == 16'd0;
    e.n = e.r[15];
    return e;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic monitor();
    exp_t act;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        exp_ret = 16'd0;
      end else begin
        chk("retired", {16'd0, retired}, {16'd0, exp_ret});
        chk("in_ready", {31'd0, in_ready}, {31'd0, !(q.size() >= 2 && !out_ready)});
        if (in_valid && !in_ready) saw_stall = 1;
        if (out_valid) begin
          act = {result, dest_out, flag_z, flag_n, flag_c, flag_v, illegal};
          if (q.size() == 0) chk("spurious_out", {9'd0, act}, 32'h0);
          else begin
            chk("out", {9'd0, act}, {9'd0, q[0]});
            if (out_ready) begin
              void'(q.pop_front());
              exp_ret++;
            end
          end
        end
        if (in_valid && in_ready) q.push_back(model(alu_code, operand_a, operand_b, dest_in));
      end
    end
  endtask
  task automatic tick();
    @(posedge clk); #1;
    if (hold > 0) begin
      out_ready = 1'b0;
      hold--;
    end else out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask
  task automatic send(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
    bit acc = 0;
    in_valid = 1'b1;
    alu_code = c;
    operand_a = a;
    operand_b = b;
    dest_in = t;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && (q.size() != 0 || out_valid); i++) tick();
    if (q.size() != 0 || out_valid) chk("drain_timeout", 32'd0, 32'd1);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_retired", {16'd0, retired}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic lat_op(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
    send(c, a, b, t);
    chk("lat_edge_n", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat_edge_n1", {31'd0, out_valid}, 32'd1);
  endtask
  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    alu_code = 4'd0;
    operand_a = 16'd0;
    operand_b = 16'd0;
    dest_in = 4'd0;
    fork monitor(); join_none
    #1;
    chk("reset_state", {out_valid, result, dest_out, flag_z, flag_n, flag_c, flag_v, illegal, in_ready},
        {1'b0, 16'd0, 4'd0, 5'd0, 1'b1});
    chk("reset_retired", {16'd0, retired}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);
    lat_op(4'd1, 16'h7FFF, 16'h0001, 4'd3);
    chk("add_ovf", {result, dest_out, flag_z, flag_n, flag_c, flag_v, illegal},
        {16'h8000, 4'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    drain();
    send(4'd2, 16'h0001, 16'h0002, 4'd1);
    send(4'd2, 16'h0005, 16'h0005, 4'd2);
    send(4'd5, 16'hFFFE, 16'h0001, 4'd4);
    send(4'd5, 16'h0001, 16'hFFFE, 4'd5);
    send(4'd3, 16'hF0F0, 16'h0FF0, 4'd6);
    send(4'd4, 16'hF0F0, 16'h0FF0, 4'd7);
    send(4'b1010, 16'h1234, 16'h0000, 4'd8);
    send(4'd1, 16'h0002, 16'h0003, 4'd9);
    drain();
    do_reset();
    saw_stall = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) hold = 3;
      send(4'd1, 16'($urandom), 16'($urandom), 4'(i));
    end
    drain();
    chk("stall_seen", {31'd0, saw_stall}, 32'd1);
    chk("retired_8", {16'd0, retired}, 32'd8);
    hold = 1000;
    out_ready = 1'b0;
    send(4'd1, 16'h1111, 16'h2222, 4'd1);
    send(4'd2, 16'h3333, 16'h4444, 4'd2);
    chk("both_full_valid", {31'd0, out_valid}, 32'd1);
    chk("both_full_ready", {31'd0, in_ready}, 32'd0);
    hold = 0;
    do_reset();
    lat_op(4'd2, 16'h0010, 16'h0001, 4'd6);
    drain();
    rnd = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) tick();
      send(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 4'($urandom));
    end
    drain();
    rnd = 0;
    do_reset();
    for (int i = 0; i < 65535; i++)
      send(4'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 4'($urandom));
    drain();
    chk("retired_ffff", {16'd0, retired}, 32'h0000FFFF);
    send(4'd1, 16'h0001, 16'h0001, 4'd0);
    drain();
    chk("retired_wrap", {16'd0, retired}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
